uart_rx_frame: RTL and testbench
================================

// Module: uart_rx_frame
// PURPOSE
//  UART receive datapath, the far end of the TX serializer/parity path. Oversamples RX_IN,
//  detects the start bit, deserialises WIDTH data bits LSB-first, then checks optional parity and the stop bit.
//  Presents the received word with a 1-cycle valid strobe, or a 1-cycle error strobe.
//  Sits between the pad-side RX line and the RX FIFO/register interface.
// PARAMETERS
//  WIDTH       8  data bits per frame
//  OVERSAMPLE  8  CLK cycles per bit; even, >= 4
// PORTS
//  CLK            in   1      system clock, all logic on rising edge
//  RST            in   1      asynchronous, active-high reset
//  RX_IN          in   1      serial line, idle high, asynchronous to CLK
//  parity_enable  in   1      1 = frame carries a parity bit after data
//  PAR_TYP        in   1      0 = even (bit = ^data), 1 = odd (bit = ~^data)
//  P_DATA         out  WIDTH  last good word; holds until next good frame
//  data_valid     out  1      1-cycle pulse: P_DATA updated, frame good
//  parity_error   out  1      1-cycle pulse: parity mismatch
//  stop_error     out  1      1-cycle pulse: stop bit sampled 0
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high (CLK, RST). Reset value: P_DATA=0, strobes=0, state IDLE,
//    counters 0, sync flops=1. Reset mid-frame aborts the frame; no strobe is issued.
//  - RX_IN passes through a 2-flop synchroniser (rx_s); all timing below is relative to rx_s.
//  - edge_cnt counts 0..OVERSAMPLE-1 within a bit and wraps. bit_cnt advances on each wrap.
//  - Sample point: MID = OVERSAMPLE/2. The bit value is decided at the decision cycle (see CONFIGURATION).
//  - FSM:
//    IDLE: first cycle with rx_s==0 -> START, edge_cnt=0. Latch parity_enable/PAR_TYP; mid-frame changes are ignored.
//    START: at decision, bit==1 -> IDLE (glitch, no strobe). At wrap -> DATA.
//    DATA: at decision, shift bit into shift reg LSB-first. At wrap of bit WIDTH-1 -> PARITY if enabled, else STOP.
//    PARITY: at decision, compare with expected parity (PAR_TYP 0: ^shift, 1: ~^shift). Store mismatch flag.
//      At wrap -> STOP.
//    STOP: at decision, return to IDLE in the next cycle. This mid-stop resync allows back-to-back frames.
//      Exactly one strobe is issued, in that cycle. Priority: stop_error, then parity_error, then data_valid.
//      Only data_valid loads P_DATA.
//  - Latency: data_valid asserts 1 cycle after the stop-bit decision cycle, plus 2 synchroniser cycles from the pin.
//  - Line held low (break): stop_error, then IDLE sees rx_s==0 and restarts. That frame fails at stop again.
//  - Strobes are mutually exclusive and never last longer than 1 cycle.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined:
//    Samples at MID-1, MID and MID+1; bit = majority of the 3. Decision cycle is edge_cnt==MID+1.
//  Undefined:
//    Single sample at edge_cnt==MID, which is also the decision cycle.
//  Frame timing and port behaviour are otherwise identical.
// STRUCTURE
//  - uart_pkg: FSM state encoding (IDLE, START, DATA, PARITY, STOP); PAR_EVEN=1'b0 and PAR_ODD=1'b1,
//    shared with the TX parity calculator.
//  - Sub-module uart_rx_sampler: synchroniser, edge_cnt, and sample/majority logic.
//    Outputs sampled_bit, decide and bit_end strobes.
//  - Top level: FSM, bit_cnt, shift register, parity/stop check, and output registers.
// TESTING (WIDTH=8, OVERSAMPLE=8, OVERSAMPLE clk/bit)
//  1. parity_enable=0; send 0xA5 with stop=1 -> single data_valid, P_DATA=0xA5, no errors.
//  2. parity_enable=1, PAR_TYP=0; send 0xA5 with parity bit 0 -> data_valid, P_DATA=0xA5.
//     Same frame with parity bit 1 -> parity_error only, P_DATA unchanged.
//  3. PAR_TYP=1; send 0x01 with parity bit 0 -> data_valid.
//     Send 0x01 with stop bit 0 -> stop_error only, no parity_error.
//  4. Low pulse of 2 clk on idle line -> no strobe, FSM back to IDLE. Then a frame of 0x3C -> data_valid, P_DATA=0x3C.
//  5. Assert RST during data bit 4 of a frame -> all outputs 0 immediately. No strobe.
//     The next full frame 0x55 is received correctly.
//  6. Macro on: 1-clk inverted glitch at MID of data bit 2 of 0xF0 -> P_DATA=0xF0.
//     Macro off: glitch on MID itself -> P_DATA=0xF4.
//     Also cover back-to-back frames 0x12, 0x34 with one stop bit each -> two data_valid pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, parity-type codes used by both
// the TX parity calculator and the RX checker, and a 3-input majority helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line synchroniser, per-bit oversample counter and bit-value sampler (UART_RX_MAJORITY_EN: 3-sample majority vote).
// Latency: 2 cycles pin-to-rx_s; decide fires at edge_cnt==MID (MID+1 with majority vote).
// Backpressure: none; strobes are single-cycle and only generated while run is high.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic rx_in,
    input  logic run,
    output logic rx_s,
    output logic sampled_bit,
    output logic decide,
    output logic bit_end
);

    localparam int CW  = $clog2(OVERSAMPLE);
    localparam int MID = OVERSAMPLE / 2;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] edge_cnt;

    // Counter is held at zero while idle so every frame starts its bit timing fresh.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            edge_cnt <= '0;
        end else begin
            sync1 <= rx_in;
            sync2 <= sync1;
            if (!run || bit_end) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

    assign rx_s    = sync2;
    assign bit_end = run && (edge_cnt == CW'(OVERSAMPLE - 1));

`ifdef UART_RX_MAJORITY_EN
    logic s_lo;
    logic s_mid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s_lo  <= 1'b1;
            s_mid <= 1'b1;
        end else begin
            if (run && (edge_cnt == CW'(MID - 1))) begin
                s_lo <= rx_s;
            end
            if (run && (edge_cnt == CW'(MID))) begin
                s_mid <= rx_s;
            end
        end
    end

    // Third vote is the live sample at MID+1, so the decision is made that same cycle.
    assign sampled_bit = maj3(s_lo, s_mid, rx_s);
    assign decide      = run && (edge_cnt == CW'(MID + 1));
`else
    assign sampled_bit = rx_s;
    assign decide      = run && (edge_cnt == CW'(MID));
`endif

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start detect, LSB-first deserialise, optional parity and stop check (UART_RX_MAJORITY_EN in sampler).
// Latency: strobe one cycle after the stop-bit decision, plus 2 synchroniser cycles from the pin.
// Backpressure: none; exactly one single-cycle strobe per completed frame, P_DATA held until next good frame.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RX_IN,
    input  logic             parity_enable,
    input  logic             PAR_TYP,
    output logic [WIDTH-1:0] P_DATA,
    output logic             data_valid,
    output logic             parity_error,
    output logic             stop_error
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    uart_state_t      state;
    uart_state_t      state_n;
    logic [BW-1:0]    bit_cnt;
    logic [BW-1:0]    bit_cnt_n;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_n;
    logic [WIDTH-1:0] p_data_n;
    logic             par_en_q;
    logic             par_en_n;
    logic             par_typ_q;
    logic             par_typ_n;
    logic             par_err_q;
    logic             par_err_n;
    logic             data_valid_n;
    logic             parity_error_n;
    logic             stop_error_n;
    logic             exp_par;

    logic rx_s;
    logic sampled_bit;
    logic decide;
    logic bit_end;
    logic run;

    assign run = (state != ST_IDLE);

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_sampler (
        .CLK        (CLK),
        .RST        (RST),
        .rx_in      (RX_IN),
        .run        (run),
        .rx_s       (rx_s),
        .sampled_bit(sampled_bit),
        .decide     (decide),
        .bit_end    (bit_end)
    );

    assign exp_par = (par_typ_q == PAR_EVEN) ? ^shift_q : ~^shift_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_err_q    <= 1'b0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_cnt_n;
            shift_q      <= shift_n;
            par_en_q     <= par_en_n;
            par_typ_q    <= par_typ_n;
            par_err_q    <= par_err_n;
            P_DATA       <= p_data_n;
            data_valid   <= data_valid_n;
            parity_error <= parity_error_n;
            stop_error   <= stop_error_n;
        end
    end

    always_comb begin
        state_n        = state;
        bit_cnt_n      = bit_cnt;
        shift_n        = shift_q;
        par_en_n       = par_en_q;
        par_typ_n      = par_typ_q;
        par_err_n      = par_err_q;
        p_data_n       = P_DATA;
        data_valid_n   = 1'b0;
        parity_error_n = 1'b0;
        stop_error_n   = 1'b0;

        case (state)
            ST_IDLE: begin
                // Frame format is frozen here; later changes on the inputs do not affect this frame.
                if (!rx_s) begin
                    state_n   = ST_START;
                    bit_cnt_n = '0;
                    par_en_n  = parity_enable;
                    par_typ_n = PAR_TYP;
                    par_err_n = 1'b0;
                end
            end
            ST_START: begin
                if (decide && sampled_bit) begin
                    state_n = ST_IDLE;
                end else if (bit_end) begin
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (decide) begin
                    shift_n = {sampled_bit, shift_q[WIDTH-1:1]};
                end
                if (bit_end) begin
                    if (bit_cnt == BW'(WIDTH - 1)) begin
                        bit_cnt_n = '0;
                        state_n   = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (decide) begin
                    par_err_n = (sampled_bit != exp_par);
                end
                if (bit_end) begin
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop lets the next start edge be caught without losing a bit.
                if (decide) begin
                    state_n = ST_IDLE;
                    if (!sampled_bit) begin
                        stop_error_n = 1'b1;
                    end else if (par_err_q) begin
                        parity_error_n = 1'b1;
                    end else begin
                        data_valid_n = 1'b1;
                        p_data_n     = shift_q;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed scenarios plus randomized frames against a frame-level model.
module tb_uart_rx_frame;
    import uart_pkg::*;

    localparam int W   = 8;
    localparam int OS  = 8;
    localparam int MID = OS / 2;

    logic         CLK = 1'b0;
    logic         RST;
    logic         RX_IN;
    logic         parity_enable;
    logic         PAR_TYP;
    logic [W-1:0] P_DATA;
    logic         data_valid;
    logic         parity_error;
    logic         stop_error;

    uart_rx_frame #(.WIDTH(W), .OVERSAMPLE(OS)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .parity_enable(parity_enable),
        .PAR_TYP      (PAR_TYP),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tot_dv = 0, tot_pe = 0, tot_se = 0, tot_multi = 0;
    int last_dv_cyc = 0;
    int last_bit_cyc = 0;
    logic [W-1:0] dv_log [0:511];
    int s_dv, s_pe, s_se, s_multi;
    logic [W-1:0] exp_pdata;

    always @(posedge CLK) cyc <= cyc + 1;

    // Strobes are sampled on the falling edge; a strobe held two cycles is counted twice.
    always @(negedge CLK) begin
        if (data_valid) begin
            dv_log[tot_dv % 512] <= P_DATA;
            tot_dv      <= tot_dv + 1;
            last_dv_cyc <= cyc;
        end
        if (parity_error) tot_pe <= tot_pe + 1;
        if (stop_error)   tot_se <= tot_se + 1;
        if ((int'(data_valid) + int'(parity_error) + int'(stop_error)) > 1) tot_multi <= tot_multi + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d required < 200000", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame-level model: stop bit dominates, then parity, else the word is good.
    function automatic int model_kind(input logic [W-1:0] d, input logic pe, input logic typ,
                                      input logic pb, input logic sb);
        logic ep;
        ep = (typ == PAR_ODD) ? ~^d : ^d;
        if (!sb) return 2;
        if (pe && (pb !== ep)) return 1;
        return 0;
    endfunction

    function automatic logic good_parity(input logic [W-1:0] d, input logic typ);
        return (typ == PAR_ODD) ? ~^d : ^d;
    endfunction

    task automatic drive_bit(input logic b, input int glitch_off);
        for (int k = 0; k < OS; k++) begin
            @(negedge CLK);
            if (k == 0) last_bit_cyc = cyc;
            RX_IN = (k == glitch_off) ? ~b : b;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            RX_IN = 1'b1;
        end
    endtask

    task automatic snap();
        s_dv = tot_dv; s_pe = tot_pe; s_se = tot_se; s_multi = tot_multi;
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic pe, input logic typ, input logic pb,
                              input logic sb, input int gl_bit, input int gl_off, input logic scramble);
        logic fb [0:W+2];
        int n;
        parity_enable = pe;
        PAR_TYP = typ;
        n = 0;
        fb[n] = 1'b0; n++;
        for (int i = 0; i < W; i++) begin fb[n] = d[i]; n++; end
        if (pe) begin fb[n] = pb; n++; end
        fb[n] = sb; n++;
        for (int b = 0; b < n; b++) begin
            if (scramble && b == 2) begin
                parity_enable = 1'($urandom);
                PAR_TYP = 1'($urandom);
            end
            drive_bit(fb[b], (b == gl_bit) ? gl_off : -1);
        end
    endtask

    task automatic check_frame(input string tag, input int kind, input logic [W-1:0] d);
        int lat;
        chk({tag, "_dv"}, tot_dv - s_dv, (kind == 0) ? 1 : 0);
        chk({tag, "_pe"}, tot_pe - s_pe, (kind == 1) ? 1 : 0);
        chk({tag, "_se"}, tot_se - s_se, (kind == 2) ? 1 : 0);
        chk({tag, "_excl"}, tot_multi - s_multi, 0);
        if (kind == 0) begin
            exp_pdata = d;
            chk({tag, "_word"}, dv_log[s_dv % 512], d);
            lat = last_dv_cyc - last_bit_cyc;
            chk({tag, "_lat_ok"}, (lat >= 2 && lat <= 12) ? 1 : 0, 1);
        end
        chk({tag, "_pdata"}, P_DATA, exp_pdata);
    endtask

    task automatic run_frame(input string tag, input logic [W-1:0] d, input logic pe, input logic typ,
                             input logic pb, input logic sb, input int gl_bit, input int gl_off,
                             input logic scramble, input int gap);
        snap();
        send_frame(d, pe, typ, pb, sb, gl_bit, gl_off, scramble);
        idle(gap);
        check_frame(tag, model_kind(d, pe, typ, pb, sb), d);
    endtask

    initial begin
        logic [W-1:0] rd, glitch_exp;
        logic rpe, rtyp, rpb, rsb;

        RST = 1'b1; RX_IN = 1'b1; parity_enable = 1'b0; PAR_TYP = 1'b0;
        exp_pdata = '0;
        repeat (2) @(negedge CLK);
        #1;
        chk("reset_pdata", P_DATA, 0);
        chk("reset_strobes", {data_valid, parity_error, stop_error}, 0);
        @(negedge CLK);
        RST = 1'b0;
        idle(12);

        run_frame("t1_a5_nopar", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0, 12);
        run_frame("t2_a5_even_ok", 8'hA5, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1, -1, 1'b0, 12);
        run_frame("t2_a5_even_bad", 8'hA5, 1'b1, PAR_EVEN, 1'b1, 1'b1, -1, -1, 1'b0, 12);
        run_frame("t3_01_odd_ok", 8'h01, 1'b1, PAR_ODD, 1'b0, 1'b1, -1, -1, 1'b0, 12);
        run_frame("t3_01_stop0", 8'h01, 1'b1, PAR_ODD, 1'b0, 1'b0, -1, -1, 1'b0, 16);

        // Short low pulse on an idle line must be rejected as a false start.
        snap();
        @(negedge CLK); RX_IN = 1'b0;
        @(negedge CLK); RX_IN = 1'b0;
        idle(16);
        check_frame("t4_glitch", 3, 8'h00);
        chk("t4_state_idle", int'(dut.state), int'(ST_IDLE));
        run_frame("t4_3c", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0, 12);

        // Reset in the middle of data bit 4 aborts the frame.
        snap();
        parity_enable = 1'b0;
        drive_bit(1'b0, -1);
        for (int i = 0; i < 4; i++) drive_bit(i[0], -1);
        repeat (MID) @(negedge CLK);
        RST = 1'b1;
        RX_IN = 1'b1;
        #1;
        exp_pdata = '0;
        chk("t5_rst_pdata", P_DATA, 0);
        chk("t5_rst_strobes", {data_valid, parity_error, stop_error}, 0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        idle(16);
        check_frame("t5_abort", 3, 8'h00);
        run_frame("t5_55", 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0, 12);

        // A one-clock inversion that lands on the edge_cnt==MID sample (pin offset MID+1, one cycle
        // being spent on start detection) of data bit 2.
`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 8'hF0;
`else
        glitch_exp = 8'hF4;
`endif
        snap();
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 3, MID + 1, 1'b0);
        idle(12);
        check_frame("t6_glitch_f0", 0, glitch_exp);

        // Back-to-back frames, single stop bit, no idle gap.
        snap();
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
        send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
        idle(12);
        chk("t7_b2b_count", tot_dv - s_dv, 2);
        chk("t7_b2b_first", dv_log[s_dv % 512], 8'h12);
        chk("t7_b2b_second", dv_log[(s_dv + 1) % 512], 8'h34);
        chk("t7_b2b_errs", (tot_pe - s_pe) + (tot_se - s_se) + (tot_multi - s_multi), 0);
        exp_pdata = 8'h34;
        chk("t7_b2b_pdata", P_DATA, exp_pdata);

        for (int r = 0; r < 24; r++) begin
            rd   = W'($urandom);
            rpe  = 1'($urandom);
            rtyp = 1'($urandom);
            rpb  = good_parity(rd, rtyp) ^ ($urandom_range(0, 3) == 0);
            rsb  = ($urandom_range(0, 7) != 0);
            run_frame($sformatf("rnd%0d", r), rd, rpe, rtyp, rpb, rsb, -1, -1, 1'b1,
                      16 + $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
